sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 20 ++
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared widths, FSM states and round-robin pick for sram_arbiter
package sram_arbiter_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int SRAM_BW = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Winning port number; on a tie the port that did not win last time goes next.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter for an asynchronous 16-bit SRAM
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [SRAM_AW-1:0] addr0,
  input  logic [SRAM_AW-1:0] addr1,
  input  logic [SRAM_DW-1:0] wdata0,
  input  logic [SRAM_DW-1:0] wdata1,
  input  logic [SRAM_BW-1:0] be0,
  input  logic [SRAM_BW-1:0] be1,
  output logic               ack0,
  output logic               ack1,
  output logic [SRAM_DW-1:0] rdata0,
  output logic [SRAM_DW-1:0] rdata1,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  state_e             state;
  logic [3:0]         cnt;
  logic               last_gnt;
  logic               gnt;
  logic               cur_we;
  logic [SRAM_DW-1:0] cur_wdata;
  logic               dq_oe;
  logic               win;
  logic               win_we;
  logic [SRAM_BW-1:0] win_be;

  always_comb begin
    win    = rr_pick(req0, req1, last_gnt);
    win_we = win ? we1 : we0;
    win_be = win ? be1 : be0;
  end

  assign SRAM_DQ = dq_oe ? cur_wdata : {SRAM_DW{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      cur_we    <= 1'b0;
      cur_wdata <= '0;
      dq_oe     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt       <= win;
            last_gnt  <= win;
            cur_we    <= win_we;
            cur_wdata <= win ? wdata1 : wdata0;
            SRAM_ADDR <= win ? addr1 : addr0;
            cnt       <= 4'(ACCESS_CYCLES - 1);
            dq_oe     <= win_we;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= win_we;
            SRAM_WE_N <= ~win_we;
            SRAM_UB_N <= ~win_be[1];
            SRAM_LB_N <= ~win_be[0];
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!cur_we) begin
              if (gnt) rdata1 <= SRAM_DQ;
              else     rdata0 <= SRAM_DQ;
            end
            ack0      <= ~gnt;
            ack1      <= gnt;
            dq_oe     <= 1'b0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            state     <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
            // Release WE_N one cycle early so write data is held past its rising edge.
            if (cnt == 4'd1) SRAM_WE_N <= 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - table, directed and randomized checks of sram_arbiter against an SRAM model
module tb_sram_arbiter;

  typedef struct {
    int          port;
    logic        w;
    logic [17:0] a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [15:0] exp_rd;
    logic [15:0] exp_mem;
    logic [1:0]  exp_ublb;
    int          exp_we;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic req0, req1, we0, we1;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [17:0] sram_addr;
  wire  [15:0] dq;
  logic ce_n, oe_n, we_n, ub_n, lb_n;

  logic r5_req, r5_we;
  logic [17:0] r5_addr;
  logic [15:0] r5_wdata;
  logic [1:0]  r5_be;
  logic a5_0, a5_1;
  logic [15:0] rd5_0, rd5_1;
  logic [17:0] addr5;
  wire  [15:0] dq5;
  logic ce5, oe5, we5, ub5, lb5;
  logic [15:0] w5_last;

  logic [15:0] mem [0:262143];
  logic [15:0] ref_mem [0:7];
  logic [1:0]  hist [int];
  vec_t vecs [0:7];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_ack1 = 0;
  logic mon_en = 1'b0;
  logic use5 = 1'b0;

  int          hp[$];
  int          hc[$];
  logic [15:0] hd[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter #(.ACCESS_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .SRAM_ADDR(sram_addr), .SRAM_DQ(dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_arbiter #(.ACCESS_CYCLES(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n),
    .req0(r5_req), .req1(1'b0), .we0(r5_we), .we1(1'b0),
    .addr0(r5_addr), .addr1(18'h0), .wdata0(r5_wdata), .wdata1(16'h0),
    .be0(r5_be), .be1(2'b00), .ack0(a5_0), .ack1(a5_1),
    .rdata0(rd5_0), .rdata1(rd5_1), .SRAM_ADDR(addr5), .SRAM_DQ(dq5),
    .SRAM_CE_N(ce5), .SRAM_OE_N(oe5), .SRAM_WE_N(we5),
    .SRAM_UB_N(ub5), .SRAM_LB_N(lb5)
  );

  // Device models: full-word reads while CE_N/OE_N are low, byte-masked writes while WE_N is low.
  assign dq  = (!ce_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;
  assign dq5 = (!ce5 && !oe5) ? ~addr5[15:0] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr][7:0]  = dq[7:0];
      if (!ub_n) mem[sram_addr][15:8] = dq[15:8];
    end
    if (!ce5 && !we5) w5_last = dq5;
  end

  wire        m_ce   = use5 ? ce5   : ce_n;
  wire        m_we   = use5 ? we5   : we_n;
  wire        m_ub   = use5 ? ub5   : ub_n;
  wire        m_lb   = use5 ? lb5   : lb_n;
  wire        m_ack0 = use5 ? a5_0  : ack0;
  wire        m_ack1 = use5 ? a5_1  : ack1;
  wire [15:0] m_rd0  = use5 ? rd5_0 : rdata0;
  wire [15:0] m_rd1  = use5 ? rd5_1 : rdata1;

  function automatic logic [15:0] init_val(input logic [17:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ack1) n_ack1++;
    if (mon_en && reset_n) begin
      if (ce_n) check("idle_strobes", {28'h0, oe_n, we_n, ub_n, lb_n}, 32'hF);
      if (!oe_n) check("oe_we_overlap", we_n, 1);
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic access(input bit on5, input int port, input logic w, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] b, output int lat,
                        output logic [15:0] rd, output int ce_c, output int we_c,
                        output logic [1:0] ublb);
    int start;
    bit got;
    use5 = on5;
    @(negedge clk);
    if (on5) begin
      r5_req = 1'b1; r5_we = w; r5_addr = a; r5_wdata = d; r5_be = b;
    end else if (port == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
    end
    start = cyc; ce_c = 0; we_c = 0; ublb = 2'b11; got = 0; lat = -1; rd = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!m_ce) begin
        if (ce_c == 0) ublb = {m_ub, m_lb};
        ce_c++;
      end
      if (!m_we) we_c++;
      if (port == 0 ? m_ack0 : m_ack1) begin
        got = 1; lat = cyc - start; rd = (port == 0) ? m_rd0 : m_rd1;
      end
    end
    if (on5) r5_req = 1'b0;
    else if (port == 0) req0 = 1'b0;
    else req1 = 1'b0;
    check("ack_seen", got, 1);
    @(negedge clk);
    check("ack_single", (port == 0) ? m_ack0 : m_ack1, 0);
    use5 = 1'b0;
  endtask

  task automatic run_hold(input logic r0, input logic r1, input int n, output int start);
    hp.delete(); hc.delete(); hd.delete();
    @(negedge clk);
    req0 = r0; we0 = 1'b0; addr0 = 18'h00010;  be0 = 2'b11;
    req1 = r1; we1 = 1'b0; addr1 = 18'h3FFFF; be1 = 2'b11;
    start = cyc;
    for (int i = 0; i < 100 && hp.size() < n; i++) begin
      @(negedge clk);
      if (ack0) begin hp.push_back(0); hc.push_back(cyc); hd.push_back(rdata0); end
      if (ack1) begin hp.push_back(1); hc.push_back(cyc); hd.push_back(rdata1); end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("hold_count", hp.size(), n);
  endtask

  initial begin
    int lat, ce_c, we_c, start, g, k, n_rand;
    logic [15:0] rd;
    logic [1:0] ublb, r, ak;
    logic mlast, expw;
    bit pend [2];
    logic tw [2];
    logic [17:0] ta [2];
    logic [15:0] td [2];
    logic [1:0]  tbe [2];

    for (int i = 0; i < 262144; i++) mem[i] = init_val(18'(i));
    mem[18'h00010] = 16'hBEEF;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(18'h100 + 18'(i));

    vecs[0] = '{0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'hBEEF, 16'hBEEF, 2'b00, 0};
    vecs[1] = '{1, 1'b1, 18'h3FFFF, 16'h1234, 2'b01, 16'h0000, 16'h5A34, 2'b10, 1};
    vecs[2] = '{1, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'h5A34, 16'h5A34, 2'b00, 0};
    vecs[3] = '{0, 1'b1, 18'h00020, 16'hCAFE, 2'b10, 16'h0000, 16'hCA85, 2'b01, 1};
    vecs[4] = '{0, 1'b1, 18'h00030, 16'hFFFF, 2'b00, 16'h0000, 16'hA595, 2'b11, 1};
    vecs[5] = '{1, 1'b0, 18'h00020, 16'h0000, 2'b11, 16'hCA85, 16'hCA85, 2'b00, 0};
    vecs[6] = '{0, 1'b1, 18'h00040, 16'h1357, 2'b11, 16'h0000, 16'h1357, 2'b00, 1};
    vecs[7] = '{0, 1'b0, 18'h00040, 16'h0000, 2'b11, 16'h1357, 16'h1357, 2'b00, 0};

    reset_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
    r5_req = 0; r5_we = 0; r5_addr = '0; r5_wdata = '0; r5_be = '0;
    repeat (3) @(negedge clk);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    check("rst_strobes5", {ce5, oe5, we5, ub5, lb5}, 5'h1F);
    reset_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      access(0, vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, lat, rd, ce_c, we_c, ublb);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_ce_cycles", i), ce_c, 2);
      check($sformatf("vec%0d_we_cycles", i), we_c, vecs[i].exp_we);
      check($sformatf("vec%0d_ub_lb", i), ublb, vecs[i].exp_ublb);
      if (!vecs[i].w) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_mem", i), mem[vecs[i].a], vecs[i].exp_mem);
    end
    check("rdata1_held", rdata1, 16'hCA85);
    check("addr_held", sram_addr, 18'h00040);

    // Inputs changed after grant must not reach the bus.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00060; wdata0 = 16'h1111; be0 = 2'b11;
    @(negedge clk);
    addr0 = 18'h00061; wdata0 = 16'h2222; be0 = 2'b00;
    check("inflight_addr", sram_addr, 18'h00060);
    check("inflight_be", {ub_n, lb_n}, 2'b00);
    @(negedge clk);
    check("inflight_dq", dq, 16'h1111);
    @(negedge clk);
    check("inflight_ack", ack0, 1);
    req0 = 1'b0;
    @(negedge clk);
    check("inflight_mem60", mem[18'h00060], 16'h1111);
    check("inflight_mem61", mem[18'h00061], init_val(18'h00061));

    // A request withdrawn while the bus is busy is dropped.
    k = n_ack1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 18'h00010; be0 = 2'b11;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00020; be1 = 2'b11;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    check("drop_ack0", ack0, 1);
    req0 = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_no_ack1", n_ack1 - k, 0);

    pulse_reset();
    run_hold(1, 1, 4, start);
    if (hp.size() == 4) begin
      check("cont_first_latency", hc[0] - start, 3);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("cont_port%0d", i), hp[i], i % 2);
        check($sformatf("cont_data%0d", i), hd[i], (i % 2 == 0) ? 16'hBEEF : 16'h5A34);
        if (i > 0) check($sformatf("cont_spacing%0d", i), hc[i] - hc[i-1], 4);
      end
    end

    run_hold(1, 0, 3, start);
    if (hp.size() == 3) begin
      check("held_first_latency", hc[0] - start, 3);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("held_port%0d", i), hp[i], 0);
        if (i > 0) check($sformatf("held_spacing%0d", i), hc[i] - hc[i-1], 4);
      end
    end

    // Reset in the first ACCESS cycle of a write.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00050; wdata0 = 16'h9999; be0 = 2'b11;
    @(negedge clk);
    check("rstmid_in_access", {ce_n, we_n}, 2'b00);
    reset_n = 1'b0;
    #1;
    check("rstmid_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    req0 = 1'b0;
    k = n_ack1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_no_ack", {ack1, ack0}, 0);
    end
    reset_n = 1'b1;
    access(0, 1, 1'b0, 18'h00010, 16'h0, 2'b11, lat, rd, ce_c, we_c, ublb);
    check("rstmid_after_latency", lat, 3);
    check("rstmid_after_rdata", rd, 16'hBEEF);

    access(1, 0, 1'b0, 18'h00123, 16'h0, 2'b11, lat, rd, ce_c, we_c, ublb);
    check("sweep_rd_latency", lat, 6);
    check("sweep_rd_ce", ce_c, 5);
    check("sweep_rd_we", we_c, 0);
    check("sweep_rd_data", rd, 16'hFEDC);
    access(1, 0, 1'b1, 18'h00200, 16'hABCD, 2'b11, lat, rd, ce_c, we_c, ublb);
    check("sweep_wr_latency", lat, 6);
    check("sweep_wr_ce", ce_c, 5);
    check("sweep_wr_we", we_c, 4);
    check("sweep_wr_data", w5_last, 16'hABCD);
    check("sweep_wr_addr", addr5, 18'h00200);

    // Randomized traffic against a transaction-level model.
    pulse_reset();
    mlast = 1'b1; n_rand = 0;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      ak = {ack1, ack0};
      if (ak == 2'b11) check("rand_dual_ack", ak, 2'b01);
      for (int p = 0; p < 2; p++) begin
        if (ak[p]) begin
          n_rand++;
          g = cyc - 3;
          r = hist.exists(g) ? hist[g] : 2'b00;
          expw = (r == 2'b11) ? ~mlast : r[1];
          check("rand_pending", pend[p], 1);
          check("rand_req_at_grant", r[p], 1);
          check("rand_winner", p, {31'b0, expw});
          mlast = p[0];
          k = int'(ta[p][2:0]);
          if (!tw[p]) begin
            check("rand_rdata", (p == 0) ? rdata0 : rdata1, ref_mem[k]);
          end else begin
            if (tbe[p][0]) ref_mem[k][7:0]  = td[p][7:0];
            if (tbe[p][1]) ref_mem[k][15:8] = td[p][15:8];
          end
          pend[p] = 0;
        end
      end
      if (c < 500) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(2) == 0) begin
            pend[p] = 1;
            tw[p]  = 1'($urandom_range(1));
            ta[p]  = 18'h100 + 18'($urandom_range(7));
            td[p]  = 16'($urandom);
            tbe[p] = tw[p] ? 2'($urandom_range(3)) : 2'b11;
          end
        end
      end
      req0 = pend[0]; we0 = tw[0]; addr0 = ta[0]; wdata0 = td[0]; be0 = tbe[0];
      req1 = pend[1]; we1 = tw[1]; addr1 = ta[1]; wdata1 = td[1]; be1 = tbe[1];
      hist[cyc] = {req1, req0};
      if (c >= 500 && !pend[0] && !pend[1]) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rand_drained", {pend[1], pend[0]}, 0);
    check("rand_activity", n_rand >= 40, 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("rand_mem%0d", i), mem[18'h100 + 18'(i)], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
